// File: rtl/watch_timebase_ctrl.sv
// watch_timebase_ctrl: ms/second time base, HH:MM:SS counters and time-setting mode machine
module watch_timebase_ctrl #(
  parameter int TICK_DIV      = 50_000,
  parameter int TICKS_PER_SEC = 1000,
  parameter int BLINK_TICKS   = 250
) (
  input  logic       CLOCK,
  input  logic       RST_N,
  input  logic       KEY_MODE,
  input  logic       KEY_INC,
  output logic [4:0] HOUR,
  output logic [5:0] MIN,
  output logic [5:0] SEC,
  output logic [1:0] MODE,
  output logic       BLINK,
  output logic       SEC_TICK
);
  localparam int MW = $clog2(TICK_DIV + 1);
  localparam int PW = $clog2(TICKS_PER_SEC + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam logic [MW-1:0] MS_LAST  = MW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_TICKS - 1);
  typedef enum logic [1:0] {RUN = 2'd0, SET_H = 2'd1, SET_M = 2'd2} state_t;
  state_t          state_q, state_d;
  logic [MW-1:0]   ms_q, ms_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [BW-1:0]   blk_cnt_q, blk_cnt_d;
  logic [4:0]      hour_q, hour_d;
  logic [5:0]      min_q, min_d;
  logic [5:0]      sec_q, sec_d;
  logic            blink_q, blink_d;
  logic            tick_q, tick_d;
  logic            sec_evt_q, sec_evt_d;
  logic            mode_r_q, mode_p_q, inc_r_q, inc_p_q;
  logic            ms_tick, sec_evt, mode_edge, inc_edge;
  // Next-state logic: time base, key edges, mode sequencing, counters and blink.
  // The second event is registered once so SEC advances one edge after the
  // prescaler wraps; a mode edge in RUN swallows a coinciding second so that
  // SEC_TICK never shows up alongside a SET mode.
  always_comb begin
    ms_tick   = ms_q == MS_LAST;
    sec_evt   = ms_tick && pre_q == PRE_LAST;
    mode_edge = mode_r_q & ~mode_p_q;
    inc_edge  = inc_r_q & ~inc_p_q;
    state_d   = state_q;
    ms_d      = ms_tick ? '0 : ms_q + 1'b1;
    pre_d     = ms_tick ? (pre_q == PRE_LAST ? '0 : pre_q + 1'b1) : pre_q;
    sec_evt_d = sec_evt;
    hour_d    = hour_q;
    min_d     = min_q;
    sec_d     = sec_q;
    tick_d    = 1'b0;
    blink_d   = blink_q;
    blk_cnt_d = blk_cnt_q;
    if (mode_edge) begin
      state_d   = state_q == RUN ? SET_H : state_q == SET_H ? SET_M : RUN;
      blink_d   = 1'b0;
      blk_cnt_d = '0;
      if (state_q == SET_M) begin
        sec_d     = '0;
        ms_d      = '0;
        pre_d     = '0;
        sec_evt_d = 1'b0;
      end
    end else if (state_q == RUN) begin
      blink_d   = 1'b0;
      blk_cnt_d = '0;
      if (sec_evt_q) begin
        tick_d = 1'b1;
        sec_d  = sec_q == 6'd59 ? 6'd0 : sec_q + 6'd1;
        if (sec_q == 6'd59) min_d = min_q == 6'd59 ? 6'd0 : min_q + 6'd1;
        if (sec_q == 6'd59 && min_q == 6'd59) hour_d = hour_q == 5'd23 ? 5'd0 : hour_q + 5'd1;
      end
    end else begin
      if (inc_edge && state_q == SET_H) hour_d = hour_q == 5'd23 ? 5'd0 : hour_q + 5'd1;
      if (inc_edge && state_q == SET_M) min_d = min_q == 6'd59 ? 6'd0 : min_q + 6'd1;
      if (ms_tick) begin
        blk_cnt_d = blk_cnt_q == BLK_LAST ? '0 : blk_cnt_q + 1'b1;
        blink_d   = blk_cnt_q == BLK_LAST ? ~blink_q : blink_q;
      end
    end
  end
  // State register with synchronous active-low reset; key history sampled here too.
  always_ff @(posedge CLOCK) begin
    if (!RST_N) begin
      state_q   <= RUN;
      ms_q      <= '0;
      pre_q     <= '0;
      blk_cnt_q <= '0;
      hour_q    <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      blink_q   <= 1'b0;
      tick_q    <= 1'b0;
      sec_evt_q <= 1'b0;
      mode_r_q  <= 1'b0;
      mode_p_q  <= 1'b0;
      inc_r_q   <= 1'b0;
      inc_p_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ms_q      <= ms_d;
      pre_q     <= pre_d;
      blk_cnt_q <= blk_cnt_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      blink_q   <= blink_d;
      tick_q    <= tick_d;
      sec_evt_q <= sec_evt_d;
      mode_r_q  <= KEY_MODE;
      mode_p_q  <= mode_r_q;
      inc_r_q   <= KEY_INC;
      inc_p_q   <= inc_r_q;
    end
  end
  assign HOUR     = hour_q;
  assign MIN      = min_q;
  assign SEC      = sec_q;
  assign MODE     = state_q;
  assign BLINK    = blink_q;
  assign SEC_TICK = tick_q;
endmodule

// File: tb/tb_watch_timebase_ctrl.sv
// tb_watch_timebase_ctrl: random and directed stimulus checked against a seconds-of-day reference model
module tb_watch_timebase_ctrl;
  localparam int TD = 4, TPS = 5, BT = 2;
  logic       CLOCK = 1'b0, RST_N = 1'b0, KEY_MODE = 1'b0, KEY_INC = 1'b0;
  logic [4:0] HOUR;
  logic [5:0] MIN, SEC;
  logic [1:0] MODE;
  logic       BLINK, SEC_TICK;
  int n_cmp = 0, n_bad = 0;
  int t, md, blk, nt, cyc;
  bit pend, tk, mr, mp, ir, ip;

  watch_timebase_ctrl #(.TICK_DIV(TD), .TICKS_PER_SEC(TPS), .BLINK_TICKS(BT)) dut (
    .CLOCK(CLOCK), .RST_N(RST_N), .KEY_MODE(KEY_MODE), .KEY_INC(KEY_INC),
    .HOUR(HOUR), .MIN(MIN), .SEC(SEC), .MODE(MODE), .BLINK(BLINK), .SEC_TICK(SEC_TICK)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: time kept as seconds of day, time base as edges since the last clear.
  task automatic model_edge(bit r, bit km, bit ki);
    bit me, ie, mt, se, p0;
    int m;
    if (!r) begin
      t = 0; md = 0; blk = 0; nt = 0; cyc = 0;
      pend = 0; tk = 0; mr = 0; mp = 0; ir = 0; ip = 0;
      return;
    end
    me = mr && !mp;
    ie = ir && !ip;
    mt = (cyc % TD) == TD - 1;
    se = mt && ((cyc / TD) % TPS) == TPS - 1;
    p0 = pend;
    pend = se;
    cyc++;
    tk = 0;
    if (me) begin
      if (md == 2) begin
        t -= t % 60;
        cyc = 0;
        pend = 0;
      end
      md = (md + 1) % 3;
      nt = 0;
      blk = 0;
    end else if (md == 0) begin
      if (p0) begin
        t = (t + 1) % 86400;
        tk = 1;
      end
      nt = 0;
      blk = 0;
    end else begin
      if (ie && md == 1) t = (t + 3600) % 86400;
      if (ie && md == 2) begin
        m = (t / 60) % 60;
        t += (((m + 1) % 60) - m) * 60;
      end
      if (mt) nt++;
      blk = (nt / BT) % 2;
    end
    mp = mr; mr = km; ip = ir; ir = ki;
  endtask

  task automatic step(bit r, bit km, bit ki);
    @(negedge CLOCK);
    RST_N = r; KEY_MODE = km; KEY_INC = ki;
    @(posedge CLOCK);
    model_edge(r, km, ki);
    #1;
    chk("HOUR", HOUR, t / 3600);
    chk("MIN", MIN, (t / 60) % 60);
    chk("SEC", SEC, t % 60);
    chk("MODE", MODE, md);
    chk("BLINK", BLINK, blk);
    chk("SEC_TICK", SEC_TICK, tk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1, 0, 0);
  endtask

  task automatic pulse_mode();
    step(1, 1, 0);
    step(1, 0, 0);
  endtask

  task automatic pulse_inc(int n);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 1);
      step(1, 0, 0);
    end
  endtask

  initial begin
    int first_tick, ticks, waited;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("rst_sec", SEC, 0);
    chk("rst_mode", MODE, 0);
    first_tick = -1;
    ticks = 0;
    for (int e = 0; e <= 40; e++) begin
      step(1, 0, 0);
      if (SEC_TICK) begin
        ticks++;
        if (first_tick < 0) first_tick = e;
      end
    end
    chk("first_tick_edge", first_tick, 20);
    chk("ticks_in_41", ticks, 2);
    chk("sec_at_40", SEC, 2);
    step(1, 0, 1);
    step(1, 0, 0);
    idle(3);
    pulse_mode();
    pulse_inc(23);
    pulse_mode();
    pulse_inc(59);
    pulse_mode();
    chk("set_sec_cleared", SEC, 0);
    chk("back_to_run", MODE, 0);
    idle(1181);
    chk("pre_roll_h", HOUR, 23);
    chk("pre_roll_m", MIN, 59);
    chk("pre_roll_s", SEC, 59);
    idle(20);
    chk("roll_h", HOUR, 0);
    chk("roll_m", MIN, 0);
    chk("roll_s", SEC, 0);
    chk("roll_tick", SEC_TICK, 1);
    pulse_mode();
    for (int i = 0; i < 10; i++) step(1, 0, 1);
    step(1, 0, 0);
    chk("held_inc", HOUR, 1);
    pulse_inc(4);
    pulse_inc(24);
    chk("inc_24_wrap", HOUR, 5);
    idle(100);
    step(1, 1, 1);
    step(1, 0, 0);
    chk("both_mode", MODE, 2);
    chk("both_hour", HOUR, 5);
    waited = 0;
    while (BLINK !== 1'b1 && waited < 20) begin
      step(1, 0, 0);
      waited++;
    end
    chk("blink_seen", BLINK, 1);
    step(0, 0, 0);
    chk("mid_rst_hour", HOUR, 0);
    chk("mid_rst_mode", MODE, 0);
    chk("mid_rst_blink", BLINK, 0);
    idle(30);
    pulse_mode();
    pulse_mode();
    pulse_inc(2);
    idle(7);
    pulse_mode();
    idle(25);
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 799) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
